// File: rtl/pipelined_multiplier.sv
// Fully pipelined WIDTH x WIDTH multiplier with per-stage bubble collapsing, flush and tag pass-through.
// Define MUL_OUT_SKID_EN to add a one-entry output skid buffer that breaks the iReadyOut -> oReady path.
`ifndef XLEN
`define XLEN 64
`endif

module pipelined_multiplier #(
    parameter int unsigned WIDTH  = `XLEN,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               iValidIn,
    output logic               oReady,
    input  logic [WIDTH-1:0]   iMulc,
    input  logic [WIDTH-1:0]   iMulr,
    input  logic               iSignC,
    input  logic               iSignR,
    input  logic               iWord,
    input  logic [TAG_W-1:0]   iTag,
    input  logic               iFlush,
    output logic               oValid,
    input  logic               iReadyOut,
    output logic [WIDTH-1:0]   oRsltHi,
    output logic [WIDTH-1:0]   oRsltLo,
    output logic [TAG_W-1:0]   oTag
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned LAST = STAGES - 1;

    function automatic logic [2*WIDTH-1:0] mul_fn(input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                                                  input logic word);
        logic signed [2*WIDTH+1:0] ea;
        logic signed [2*WIDTH+1:0] eb;
        logic signed [2*WIDTH+1:0] full;
        logic [HALF-1:0]           p;
        ea   = {{(WIDTH+1){a[WIDTH]}}, a};
        eb   = {{(WIDTH+1){b[WIDTH]}}, b};
        full = ea * eb;
        p    = a[HALF-1:0] * b[HALF-1:0];
        if (word)
            return {{WIDTH{p[HALF-1]}}, {HALF{p[HALF-1]}}, p};
        return full[2*WIDTH-1:0];
    endfunction

    logic [STAGES-1:0]  valid;
    logic [STAGES-1:0]  src_valid;
    logic [STAGES-1:0]  adv;
    logic [STAGES-1:0]  mask;
    logic               adv_tail;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     a_q;
    logic [WIDTH:0]     b_q;
    logic               word_q;
    logic [TAG_W-1:0]   tag0_q;
    logic [2*WIDTH-1:0] res_s [STAGES];
    logic [TAG_W-1:0]   tag_s [STAGES];

    assign a_ext = {iSignC & ~iWord & iMulc[WIDTH-1], iMulc};
    assign b_ext = {iSignR & ~iWord & iMulr[WIDTH-1], iMulr};

`ifdef MUL_OUT_SKID_EN
    logic               skid_full;
    logic [2*WIDTH-1:0] skid_res;
    logic [TAG_W-1:0]   skid_tag;

    assign adv_tail = !skid_full;
`else
    assign adv_tail = !valid[LAST] || iReadyOut;
`endif

    // adv[k] unrolled as "any stage at or beyond k is empty, or the tail can move"
    always_comb begin
        adv       = '0;
        mask      = '0;
        src_valid = '0;
        src_valid[0] = iValidIn;
        for (int unsigned k = 1; k < STAGES; k++)
            src_valid[k] = valid[k-1];
        for (int unsigned k = 0; k < STAGES; k++) begin
            mask   = ~((STAGES'(1) << k) - STAGES'(1));
            adv[k] = adv_tail || ((~valid & mask) != '0);
        end
    end

    assign oReady = adv[0];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            valid <= '0;
        end else if (iFlush) begin
            valid <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++)
                if (adv[k])
                    valid[k] <= src_valid[k];
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            a_q    <= '0;
            b_q    <= '0;
            word_q <= 1'b0;
            tag0_q <= '0;
        end else if (adv[0] && iValidIn) begin
            a_q    <= a_ext;
            b_q    <= b_ext;
            word_q <= iWord;
            tag0_q <= iTag;
        end
    end

    // Stage 0 holds operands; its result view is the product that stage 1 captures.
    assign res_s[0] = mul_fn(a_q, b_q, word_q);
    assign tag_s[0] = tag0_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic [2*WIDTH-1:0] res_r;
        logic [TAG_W-1:0]   tag_r;

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                res_r <= '0;
                tag_r <= '0;
            end else if (adv[k] && valid[k-1]) begin
                res_r <= res_s[k-1];
                tag_r <= tag_s[k-1];
            end
        end

        assign res_s[k] = res_r;
        assign tag_s[k] = tag_r;
    end

`ifdef MUL_OUT_SKID_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            skid_full <= 1'b0;
            skid_res  <= '0;
            skid_tag  <= '0;
        end else if (iFlush) begin
            skid_full <= 1'b0;
        end else if (skid_full) begin
            if (iReadyOut)
                skid_full <= 1'b0;
        end else if (valid[LAST] && !iReadyOut) begin
            skid_full <= 1'b1;
            skid_res  <= res_s[LAST];
            skid_tag  <= tag_s[LAST];
        end
    end

    assign oValid             = skid_full || valid[LAST];
    assign {oRsltHi, oRsltLo} = skid_full ? skid_res : res_s[LAST];
    assign oTag               = skid_full ? skid_tag : tag_s[LAST];
`else
    assign oValid             = valid[LAST];
    assign {oRsltHi, oRsltLo} = res_s[LAST];
    assign oTag               = tag_s[LAST];
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed self-checking bench for pipelined_multiplier (WIDTH=64, STAGES=3, TAG_W=5).
`timescale 1ns/1ps

module tb_pipelined_multiplier;
`ifdef MUL_OUT_SKID_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 3;
`endif

    logic        clk = 1'b0;
    logic        nRst;
    logic        iValidIn;
    logic        oReady;
    logic [63:0] iMulc;
    logic [63:0] iMulr;
    logic        iSignC;
    logic        iSignR;
    logic        iWord;
    logic [4:0]  iTag;
    logic        iFlush;
    logic        oValid;
    logic        iReadyOut;
    logic [63:0] oRsltHi;
    logic [63:0] oRsltLo;
    logic [4:0]  oTag;

    pipelined_multiplier #(.WIDTH(64), .STAGES(3), .TAG_W(5)) dut (
        .clk(clk), .nRst(nRst), .iValidIn(iValidIn), .oReady(oReady),
        .iMulc(iMulc), .iMulr(iMulr), .iSignC(iSignC), .iSignR(iSignR),
        .iWord(iWord), .iTag(iTag), .iFlush(iFlush), .oValid(oValid),
        .iReadyOut(iReadyOut), .oRsltHi(oRsltHi), .oRsltLo(oRsltLo), .oTag(oTag)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_delivered = 0;
    logic [63:0] q_hi[$];
    logic [63:0] q_lo[$];
    logic [4:0]  q_tag[$];
    logic [63:0] e_hi;
    logic [63:0] e_lo;
    logic        vld_s;

    // Backpressure vector table: operands, signs, word flag, expected hi/lo; tag = index+1
    logic [63:0] t_a  [6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h1_0000_0000, 64'hDEAD_BEEF_FFFF_FFFF,
                              64'd12345, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] t_b  [6] = '{64'd5, 64'h1_0000_0000, 64'h1234_5678_FFFF_FFFF,
                              64'd678, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic        t_sc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        t_sr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t_w  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] t_hi [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] t_lo [6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 64'h1, 64'h7F_B6F6, 64'h1, 64'h1};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_queues();
        q_hi.delete();
        q_lo.delete();
        q_tag.delete();
    endtask

    // Sample just before the edge, update the scoreboard, then advance one clock.
    task automatic tick(output logic took);
        #1;
        vld_s = oValid;
        took  = iValidIn && oReady && !iFlush;
        if (took) begin
            q_hi.push_back(e_hi);
            q_lo.push_back(e_lo);
            q_tag.push_back(iTag);
        end
        if (oValid && iReadyOut) begin
            if (q_hi.size() == 0) begin
                check("spurious_result", oValid, 1'b0);
            end else begin
                check("rslt_hi", oRsltHi, q_hi.pop_front());
                check("rslt_lo", oRsltLo, q_lo.pop_front());
                check("rslt_tag", oTag, q_tag.pop_front());
            end
            n_delivered++;
        end
        if (iFlush)
            clear_queues();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic sc, input logic sr,
                          input logic w, input logic [4:0] t, input logic [63:0] hi, input logic [63:0] lo);
        iMulc = a; iMulr = b; iSignC = sc; iSignR = sr; iWord = w; iTag = t;
        e_hi = hi; e_lo = lo;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sc, input logic sr,
                        input logic w, input logic [4:0] t, input logic [63:0] hi, input logic [63:0] lo);
        logic took;
        int   n;
        n = 0;
        took = 1'b0;
        set_op(a, b, sc, sr, w, t, hi, lo);
        iValidIn = 1'b1;
        while (!took && n < 50) begin
            tick(took);
            n++;
        end
        check("send_accepted", took, 1'b1);
        iValidIn = 1'b0;
    endtask

    task automatic drain();
        logic took;
        int   n;
        n = 0;
        iValidIn = 1'b0;
        while (q_hi.size() > 0 && n < 50) begin
            tick(took);
            n++;
        end
        check("drain_empty", q_hi.size(), 0);
    endtask

    task automatic latency_op(input logic [63:0] a, input logic [63:0] b, input logic sc, input logic sr,
                              input logic w, input logic [4:0] t, input logic [63:0] hi, input logic [63:0] lo);
        int n;
        iReadyOut = 1'b1;
        send(a, b, sc, sr, w, t, hi, lo);
        n = 1;
        while (!oValid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 3);
        drain();
    endtask

    initial begin
        logic took;
        int   idx;
        logic stall_seen;
        logic take_done;
        logic take_pend;
        int   dlv0;

        nRst = 1'b0; iValidIn = 1'b0; iFlush = 1'b0; iReadyOut = 1'b1;
        set_op('0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        #3;
        check("rst_valid", oValid, 1'b0);
        check("rst_hi", oRsltHi, 64'h0);
        check("rst_lo", oRsltLo, 64'h0);
        check("rst_tag", oTag, 5'h0);
        @(posedge clk); @(posedge clk); #1;
        nRst = 1'b1;
        #1;
        check("rst_ready", oReady, 1'b1);
        @(posedge clk); #1;

        latency_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd7,
                   64'hFFFF_FFFF_FFFF_FFFE, 64'h1);

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b0, 5'd20,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b0, 5'd21,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b0, 5'd22,
             64'h1, 64'hFFFF_FFFF_FFFF_FFFE);
        send(64'h7FFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b1, 5'd23,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        drain();

        idx = 0; stall_seen = 1'b0; take_done = 1'b0; take_pend = 1'b0;
        dlv0 = n_delivered;
        for (int c = 1; c <= 40 && (n_delivered - dlv0) < 6; c++) begin
            iReadyOut = !(c >= 2 && c <= 8);
            if (idx < 6) begin
                set_op(t_a[idx], t_b[idx], t_sc[idx], t_sr[idx], t_w[idx], 5'(idx + 1), t_hi[idx], t_lo[idx]);
                iValidIn = 1'b1;
            end else begin
                iValidIn = 1'b0;
            end
            #1;
            if (take_pend) begin
                check("ready_after_take", oReady, 1'b1);
                take_pend = 1'b0;
            end
            if (!oReady && !stall_seen) begin
                stall_seen = 1'b1;
                check("stall_depth", q_hi.size(), DEPTH);
            end
            if (stall_seen && !take_done && oValid && iReadyOut) begin
`ifdef MUL_OUT_SKID_EN
                take_pend = 1'b1;
`else
                check("ready_on_take", oReady, 1'b1);
`endif
                take_done = 1'b1;
            end
            tick(took);
            if (took)
                idx++;
        end
        iValidIn = 1'b0;
        iReadyOut = 1'b1;
        check("stall_seen", stall_seen, 1'b1);
        check("bp_delivered", n_delivered - dlv0, 6);

        send(64'd3, 64'd3, 1'b0, 1'b0, 1'b0, 5'd8, 64'h0, 64'd9);
        send(64'd4, 64'd4, 1'b0, 1'b0, 1'b0, 5'd9, 64'h0, 64'd16);
        set_op(64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 5'd10, 64'h0, 64'd25);
        iValidIn = 1'b1;
        iFlush = 1'b1;
        tick(took);
        iFlush = 1'b0;
        iValidIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(took);
            check("flush_quiet", vld_s, 1'b0);
        end
        latency_op(64'd6, 64'd7, 1'b0, 1'b0, 1'b0, 5'd11, 64'h0, 64'd42);

        iReadyOut = 1'b0;
        send(64'd2, 64'd2, 1'b0, 1'b0, 1'b0, 5'd12, 64'h0, 64'd4);
        send(64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 5'd13, 64'h0, 64'd6);
        send(64'd2, 64'd4, 1'b0, 1'b0, 1'b0, 5'd14, 64'h0, 64'd8);
        check("prereset_valid", oValid, 1'b1);
        #3;
        nRst = 1'b0;
        #1;
        check("midrst_valid", oValid, 1'b0);
        check("midrst_hi", oRsltHi, 64'h0);
        check("midrst_lo", oRsltLo, 64'h0);
        check("midrst_tag", oTag, 5'h0);
        clear_queues();
        @(posedge clk); #2;
        nRst = 1'b1;
        #1;
        check("midrst_ready", oReady, 1'b1);
        iReadyOut = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(took);
            check("no_stale", vld_s, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_multiplier.md
Name: pipelined_multiplier

Overview:
Parametrised, fully pipelined integer multiplier for the EX-stage MUL/MULH/MULHSU/MULHU/MULW group. It generalises the fixed three-deep, globally stalled multiplier with the following additions:
- configurable latency;
- per-operand signedness;
- 32-bit word mode;
- per-stage bubble collapsing;
- a flush input;
- a tag that travels with each operation.

It sits between issue and writeback with valid/ready handshakes on both sides.

Parameters:
- WIDTH, `XLEN (64), operand width; must be even and >= 8.
- STAGES, 3, number of register stages from accept to oValid (>= 1).
- TAG_W, 5, width of the pass-through tag (destination register id).

Ports:
- clk  in  1  clock, rising edge.
- nRst  in  1  asynchronous, active-low reset.
- iValidIn  in  1  upstream holds a valid operation.
- oReady  out  1  block can accept this cycle.
- iMulc  in  WIDTH  multiplicand.
- iMulr  in  WIDTH  multiplier.
- iSignC  in  1  1 = iMulc is signed.
- iSignR  in  1  1 = iMulr is signed.
- iWord  in  1  word mode (low WIDTH/2 bits only).
- iTag  in  TAG_W  opaque tag.
- iFlush  in  1  kill all in-flight operations.
- oValid  out  1  result available.
- iReadyOut  in  1  downstream accepts the result.
- oRsltHi  out  WIDTH  upper product half.
- oRsltLo  out  WIDTH  lower product half.
- oTag  out  TAG_W  tag of the presented result.

Behaviour:
- Accept: an operation is accepted when iValidIn && oReady && !iFlush.
- Output handshake: a result is consumed when oValid && iReadyOut.
- Operand extension:
  - Each operand is extended to WIDTH+1 bits: sign-extended if its sign flag is 1, zero-extended otherwise.
  - The signed (WIDTH+1)x(WIDTH+1) product is truncated to 2*WIDTH bits, giving {oRsltHi, oRsltLo}.
- Word mode (iWord=1):
  - Operands are the low WIDTH/2 bits of each input; sign flags are ignored.
  - P = low WIDTH/2 bits of the product.
  - oRsltLo = sign-extension of P to WIDTH; oRsltHi = replicated sign bit of P.
- Pipeline structure:
  - STAGES stages, each with its own valid bit; stage 0 is the input register, stage STAGES-1 drives the outputs.
  - The partial-product/reduction split across stages is free, but each stage must meet timing at the stage boundary.
- Stage advance (bubble collapsing):
  - Define adv[STAGES-1] = !valid[STAGES-1] || iReadyOut.
  - Define adv[k] = !valid[k] || adv[k+1].
  - Stage k loads from stage k-1 (or from the inputs, for k=0) when adv[k] is 1.
  - A stage that is empty while a later stage is stalled must still fill, so bubbles collapse.
- oReady = adv[0]: combinational from iReadyOut through the valid chain.
- Latency: exactly STAGES cycles from accept to oValid when never back-pressured. Throughput is 1 operation per cycle.
- Ordering: results leave in acceptance order; oTag is bit-exact with iTag.
- Output stability: while oValid && !iReadyOut, oRsltHi, oRsltLo and oTag are held stable.
- Flush:
  - iFlush=1 clears every valid bit at the next edge, regardless of iReadyOut.
  - An input presented in the same cycle is dropped.
  - A result handshaked in the flush cycle counts as delivered.
  - oReady may be 1 during flush.
- Reset (asynchronous, may occur mid-operation): all valid bits, oRsltHi, oRsltLo and oTag go to 0. oValid is 0 and oReady is 1 after reset release.
- Datapath registers of invalid stages may hold stale data, but outputs are 0 until the first valid result reaches the output stage.

Optional Feature:
Macro MUL_OUT_SKID_EN.
- Defined:
  - A 1-entry skid buffer follows stage STAGES-1.
  - adv[STAGES-1] = !skid_full, so oReady has no combinational path from iReadyOut.
  - Latency is unchanged when unstalled: the skid is bypassed when empty and iReadyOut=1.
  - Flush and reset also clear the skid.
- Undefined: no skid; oReady is combinational as described in Behaviour.

Test Plan:
- Unsigned max (WIDTH=64, STAGES=3): iMulc=iMulr=0xFFFF_FFFF_FFFF_FFFF, signs 0 -> 3 cycles later oRsltHi=0xFFFF_FFFF_FFFF_FFFE, oRsltLo=0x1.
- Sign modes with iMulc=0xFFFF_FFFF_FFFF_FFFF, iMulr=2:
  - signs 1/1 -> Hi=0xFFFF_FFFF_FFFF_FFFF, Lo=0xFFFF_FFFF_FFFF_FFFE.
  - signs 1/0 -> same Hi/Lo as 1/1.
  - signs 0/0 -> Hi=0x1, Lo=0xFFFF_FFFF_FFFF_FFFE.
- Word mode: iMulc=0x7FFF_FFFF, iMulr=2, iWord=1 -> Lo=0xFFFF_FFFF_FFFF_FFFE, Hi=0xFFFF_FFFF_FFFF_FFFF.
- Backpressure:
  - Stimulus: issue 6 back-to-back ops with tags 1..6 while iReadyOut=0 for cycles 2-8.
  - Required: oReady drops only once all 3 stages are full; all 6 results emerge in tag order with correct products.
  - Required: oReady returns 1 in the cycle after the first result is taken (combinationally in the same cycle without MUL_OUT_SKID_EN).
- Flush: 2 ops in flight plus iFlush=1 together with a new iValidIn -> no oValid in the next 5 cycles; the next accepted op appears after exactly 3 cycles.
- Reset: assert nRst=0 asynchronously with 3 ops in flight and the output stalled -> oValid=0 and outputs=0 immediately; oReady=1 after release; no stale result ever appears.
